// File: rtl/lo_passthru_guarded.sv
// LF pass-through front end for reader-driven tags.
// The ARM field request (ssp_dout) keys the antenna drivers, and the LF comparator
// output (cross_lo) is deglitched before it goes back to the ARM on ssp_din.
// A field-on watchdog drops the drivers if the request is held high for too long.
module lo_passthru_guarded #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FILT_W      = 3,
  parameter logic [3:0]  OE_MASK     = 4'b1011,
  parameter int unsigned WDOG_CYCLES = 0,
  parameter int unsigned WDOG_W      = 24
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pck_divclk,
  input  logic i_ssp_dout,
  input  logic i_cross_lo,
  output logic o_pwr_lo,
  output logic o_pwr_hi,
  output logic o_pwr_oe1,
  output logic o_pwr_oe2,
  output logic o_pwr_oe3,
  output logic o_pwr_oe4,
  output logic o_adc_clk,
  output logic o_ssp_din,
  output logic o_dbg,
  output logic o_wdog_trip
);

  localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(FILT_LEN - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST   = WDOG_W'(WDOG_CYCLES - 1);
  localparam bit                WDOG_ENABLE = (WDOG_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TRIP  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_doutSync;
  logic [SYNC_STAGES-1:0] r_loSync;
  logic                   w_doutS;
  logic                   w_loS;

  logic                   r_filt;
  logic [FILT_W-1:0]      r_filtCnt;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [WDOG_W-1:0]      r_wcnt;
  logic [WDOG_W-1:0]      w_wcntNext;
  logic                   r_driveEn;
  logic                   r_wdogTrip;

  assign w_doutS = r_doutSync[SYNC_STAGES-1];
  assign w_loS   = r_loSync[SYNC_STAGES-1];

  // Bring both asynchronous inputs into the clk domain through plain flop chains.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_doutSync <= '0;
      r_loSync   <= '0;
    end else begin
      r_doutSync <= {r_doutSync[SYNC_STAGES-2:0], i_ssp_dout};
      r_loSync   <= {r_loSync[SYNC_STAGES-2:0], i_cross_lo};
    end
  end

  // Deglitch: the filtered value only follows lo_s after FILT_LEN consecutive differing cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_filt    <= 1'b0;
      r_filtCnt <= '0;
    end else if (w_loS == r_filt) begin
      r_filtCnt <= '0;
    end else if (r_filtCnt == FILT_LAST) begin
      r_filt    <= w_loS;
      r_filtCnt <= '0;
    end else begin
      r_filtCnt <= r_filtCnt + FILT_W'(1);
    end
  end

  // Next-state and watchdog count; a request drop beats a simultaneous watchdog expiry.
  always_comb begin
    w_stateNext = r_state;
    w_wcntNext  = r_wcnt;
    case (r_state)
      ST_IDLE: begin
        w_wcntNext = '0;
        if (w_doutS) begin
          w_stateNext = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (!w_doutS) begin
          w_stateNext = ST_IDLE;
        end else if (WDOG_ENABLE && (r_wcnt == WDOG_LAST)) begin
          w_stateNext = ST_TRIP;
        end else if (r_wcnt != '1) begin
          w_wcntNext = r_wcnt + WDOG_W'(1);
        end
      end
      ST_TRIP: begin
        if (!w_doutS) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_wcntNext  = '0;
      end
    endcase
  end

  // State register with drive_en and wdog_trip registered from the next state so they never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_driveEn  <= 1'b0;
      r_wdogTrip <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_wcnt     <= w_wcntNext;
      r_driveEn  <= (w_stateNext == ST_DRIVE);
      r_wdogTrip <= (w_stateNext == ST_TRIP);
    end
  end

  assign o_pwr_lo    = i_pck_divclk & r_driveEn;
  assign o_pwr_hi    = 1'b0;
  assign o_pwr_oe1   = r_driveEn & OE_MASK[0];
  assign o_pwr_oe2   = r_driveEn & OE_MASK[1];
  assign o_pwr_oe3   = r_driveEn & OE_MASK[2];
  assign o_pwr_oe4   = r_driveEn & OE_MASK[3];
  assign o_adc_clk   = 1'b0;
  assign o_ssp_din   = r_filt;
  assign o_dbg       = r_filt;
  assign o_wdog_trip = r_wdogTrip;

endmodule

// File: tb/tb_lo_passthru_guarded.sv
// Directed bench for lo_passthru_guarded.
// dutA uses the default parameters (watchdog off); dutB has the watchdog set to 10 cycles.
// The two instances share clock, reset, carrier and cross_lo, but each has its own field request.
module tb_lo_passthru_guarded;

  logic clk;
  logic rstN;
  logic pckDivclk;
  logic crossLo;
  logic sspDoutA;
  logic sspDoutB;

  logic aPwrLo, aPwrHi, aOe1, aOe2, aOe3, aOe4, aAdcClk, aSspDin, aDbg, aTrip;
  logic bPwrLo, bPwrHi, bOe1, bOe2, bOe3, bOe4, bAdcClk, bSspDin, bDbg, bTrip;

  int vecCount;
  int missCount;

  lo_passthru_guarded dutA (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_pck_divclk (pckDivclk),
    .i_ssp_dout   (sspDoutA),
    .i_cross_lo   (crossLo),
    .o_pwr_lo     (aPwrLo),
    .o_pwr_hi     (aPwrHi),
    .o_pwr_oe1    (aOe1),
    .o_pwr_oe2    (aOe2),
    .o_pwr_oe3    (aOe3),
    .o_pwr_oe4    (aOe4),
    .o_adc_clk    (aAdcClk),
    .o_ssp_din    (aSspDin),
    .o_dbg        (aDbg),
    .o_wdog_trip  (aTrip)
  );

  lo_passthru_guarded #(.WDOG_CYCLES(10)) dutB (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_pck_divclk (pckDivclk),
    .i_ssp_dout   (sspDoutB),
    .i_cross_lo   (crossLo),
    .o_pwr_lo     (bPwrLo),
    .o_pwr_hi     (bPwrHi),
    .o_pwr_oe1    (bOe1),
    .o_pwr_oe2    (bOe2),
    .o_pwr_oe3    (bOe3),
    .o_pwr_oe4    (bOe4),
    .o_adc_clk    (bAdcClk),
    .o_ssp_din    (bSspDin),
    .o_dbg        (bDbg),
    .o_wdog_trip  (bTrip)
  );

  // Free-running 10 ns main clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive both field requests and the comparator input.
  task automatic applyStimulus(input logic doutA, input logic doutB, input logic lo);
    sspDoutA = doutA;
    sspDoutB = doutB;
    crossLo  = lo;
  endtask

  // Count one comparison and report it if it misses.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Directed sequence: reset, mask, deglitch, watchdog, re-arm, race, mid-run reset, long hold.
  initial begin
    int highCount;
    int tripCount;
    int bad;
    vecCount  = 0;
    missCount = 0;
    pckDivclk = 1'b0;
    rstN      = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);

    $display("[TB] reset with requests and cross_lo high");
    tick(3);
    checkOutput("resetOutsA", {22'd0, aPwrLo, aPwrHi, aOe1, aOe2, aOe3, aOe4, aAdcClk, aSspDin, aDbg, aTrip}, 32'd0);
    checkOutput("resetOutsB", {22'd0, bPwrLo, bPwrHi, bOe1, bOe2, bOe3, bOe4, bAdcClk, bSspDin, bDbg, bTrip}, 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("oe1Rise@2", aOe1, 1'b0);
    tick(1);
    checkOutput("oe1Rise@3", aOe1, 1'b1);

    $display("[TB] driver mask and carrier gating");
    checkOutput("maskOe1", aOe1, 1'b1);
    checkOutput("maskOe2", aOe2, 1'b1);
    checkOutput("maskOe3", aOe3, 1'b0);
    checkOutput("maskOe4", aOe4, 1'b1);
    checkOutput("pwrHi", aPwrHi, 1'b0);
    checkOutput("adcClk", aAdcClk, 1'b0);
    pckDivclk = 1'b1;
    #1;
    checkOutput("pwrLoHigh", aPwrLo, 1'b1);
    pckDivclk = 1'b0;
    #1;
    checkOutput("pwrLoLow", aPwrLo, 1'b0);
    pckDivclk = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("oe1Fall@2", aOe1, 1'b1);
    tick(1);
    checkOutput("oe1Fall@3", aOe1, 1'b0);
    checkOutput("pwrLoOff", aPwrLo, 1'b0);
    pckDivclk = 1'b0;

    $display("[TB] deglitch: 3-cycle pulse is swallowed");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 4; t <= 12; t++) begin
      checkOutput("glitch3", aSspDin, 1'b0);
      tick(1);
    end

    $display("[TB] deglitch: 4-cycle pulse passes");
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      if (t == 4) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("pulse4SspDin@%0d", t), aSspDin, (t >= 6 && t <= 9) ? 1'b1 : 1'b0);
      checkOutput($sformatf("pulse4Dbg@%0d", t), aDbg, (t >= 6 && t <= 9) ? 1'b1 : 1'b0);
    end

    $display("[TB] watchdog of 10 cycles");
    highCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      tick(1);
      if (bOe1) highCount++;
      checkOutput($sformatf("wdogOe1@%0d", t), bOe1, (t >= 3 && t <= 12) ? 1'b1 : 1'b0);
      checkOutput($sformatf("wdogTrip@%0d", t), bTrip, (t >= 13) ? 1'b1 : 1'b0);
    end
    checkOutput("wdogDriveCycles", highCount, 10);
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (bOe1 || bPwrLo || !bTrip) bad++;
    end
    checkOutput("tripHold", bad, 0);

    $display("[TB] re-arm from trip");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("rearmTripLow", bTrip, 1'b0);
    checkOutput("rearmOe1Low", bOe1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    checkOutput("rearmDrive", bOe1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("rearmIdle", bOe1, 1'b0);

    $display("[TB] request drop racing watchdog expiry");
    tripCount = 0;
    highCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      if (t == 10) applyStimulus(1'b0, 1'b0, 1'b0);
      if (bTrip) tripCount++;
      if (bOe1) highCount++;
    end
    checkOutput("raceTripCount", tripCount, 0);
    checkOutput("raceDriveCycles", highCount, 10);

    $display("[TB] reset mid-drive and mid-trip");
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(16);
    checkOutput("preResetDriveA", aOe1, 1'b1);
    checkOutput("preResetTripB", bTrip, 1'b1);
    rstN = 1'b0;
    tick(1);
    checkOutput("midResetOe1A", aOe1, 1'b0);
    checkOutput("midResetTripB", bTrip, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("postResetDriveA", aOe1, 1'b1);

    $display("[TB] long hold with watchdog disabled");
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      tick(1);
      if (aTrip || !aOe1) bad++;
    end
    checkOutput("noWdogHold", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
